fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage of the pipelined LEGv8 processor, directly upstream of the instruction memory.
- Holds the program counter and drives the 7-bit word address into the combinational instruction ROM.
- Captures the returned instruction into the IF/ID pipeline register.
- Applies stall and flush requests from hazard detection, and branch redirects from the MEM stage.
- Counts fetched instructions for debug.

Parameters:
N, 64, datapath/PC width in bits
IMEM_AW, 7, instruction memory word-address width (128 words)
NOP_INSTR, 32'h8b1f03ff, bubble encoding (ADD XZR,XZR,XZR) inserted on flush

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
stall_F  in  1  hazard unit: hold PC and IF/ID contents
flush_D  in  1  hazard unit: replace IF/ID contents with bubble
pcsrc_M  in  1  branch taken, resolved in MEM stage
pcbranch_M  in  N  branch target address
imem_addr_F  out  IMEM_AW  word address to instruction memory
imem_q_F  in  32  instruction word from instruction memory (combinational, same cycle)
pc_D  out  N  PC of the instruction held in IF/ID
instr_D  out  32  instruction held in IF/ID
valid_D  out  1  IF/ID holds a real fetched instruction (0 = bubble)
fetch_count  out  32  number of instructions loaded into IF/ID

Behaviour:
- Single clock domain. Reset is synchronous and active-high; clock port `clk`, reset port `reset`.
- Reset (highest priority, also mid-operation):
  - PC=0, pc_D=0, instr_D=NOP_INSTR, valid_D=0, fetch_count=0.
  - All other inputs are ignored in a reset cycle.
- imem_addr_F = PC[IMEM_AW+1:2], purely combinational from the PC register. No extra latency: imem_q_F is valid in the same cycle.
- PC bits [1:0] are always stored as 0; a misaligned pcbranch_M is truncated to word alignment.
- Next-PC priority per rising edge:
  1. reset -> 0
  2. pcsrc_M -> {pcbranch_M[N-1:2],2'b00}; redirect wins over stall_F
  3. stall_F -> hold PC
  4. otherwise -> PC+4, modulo 2^N
- IF/ID priority per rising edge:
  1. reset
  2. pcsrc_M or flush_D -> instr_D=NOP_INSTR, valid_D=0, pc_D=0
  3. stall_F -> hold all three outputs
  4. otherwise -> pc_D=PC, instr_D=imem_q_F, valid_D=1
- flush_D with stall_F and no pcsrc_M: IF/ID takes the bubble, PC holds.
- Fetch latency: an instruction at PC appears on instr_D one edge after PC is presented.
- Taken branch: exactly one bubble cycle in IF/ID, then the target instruction appears.
- Address wrap: PC beyond 0x1FC aliases modulo 512 bytes. PC=0x1FC gives addr 127; PC=0x200 gives addr 0. The full N-bit PC continues to increment and is reported on pc_D.
- fetch_count increments by 1 on every edge in which IF/ID takes rule 4. It saturates at 32'hFFFFFFFF and does not wrap.
- No outputs are X after the first reset edge. Behaviour before the first reset is unspecified.

Test Plan:
- Reset then free run, ROM[0..8] loaded (f8000001, f8008002, 8b050083, 8b0800a4, f8400006, …) -> after edge 1: pc_D=0, instr_D=f8000001, valid_D=1; after edge 2: pc_D=4, instr_D=f8008002; fetch_count=2.
- stall_F=1 for 2 cycles starting with PC=8 -> imem_addr_F stays 2, instr_D stays f8008002, fetch_count unchanged; on release, instr_D=8b050083, pc_D=8.
- pcsrc_M=1, pcbranch_M=0x10, with stall_F=1 in the same cycle -> next edge: valid_D=0, instr_D=8b1f03ff, PC=0x10; following edge: instr_D=f8400006, pc_D=0x10.
- flush_D=1 alone at PC=0xC -> IF/ID becomes bubble; PC advances to 0x10; the instruction at 0xC is lost; fetch_count not incremented.
- Force PC=0x1FC via branch -> imem_addr_F=127; next edge PC=0x200, imem_addr_F=0; pc_D=0x1FC with instr_D=ROM[127]=0.
- Assert reset mid-run at PC=0x18 with stall_F=1 and pcsrc_M=1 -> next edge: PC=0, valid_D=0, instr_D=8b1f03ff, fetch_count=0.

Source files
------------

// File: rtl/fetch_stage.sv
// LEGv8 instruction-fetch stage: PC register, instruction-ROM addressing and the
// IF/ID pipeline register with stall, flush and branch-redirect handling.
module fetch_stage #(
  parameter int unsigned N         = 64,
  parameter int unsigned IMEM_AW   = 7,
  parameter logic [31:0] NOP_INSTR = 32'h8b1f03ff
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_F,
  input  logic               flush_D,
  input  logic               pcsrc_M,
  input  logic [N-1:0]       pcbranch_M,
  output logic [IMEM_AW-1:0] imem_addr_F,
  input  logic [31:0]        imem_q_F,
  output logic [N-1:0]       pc_D,
  output logic [31:0]        instr_D,
  output logic               valid_D,
  output logic [31:0]        fetch_count
);

  localparam int unsigned CNT_W = 32;

  logic [N-1:0]     pc_q, pc_d;
  logic [N-1:0]     pc_D_q, pc_D_d;
  logic [31:0]      instr_D_q, instr_D_d;
  logic             valid_D_q, valid_D_d;
  logic [CNT_W-1:0] fetch_count_q, fetch_count_d;
  logic             bubble_c;
  logic             load_c;

  // IF/ID takes a bubble on redirect or flush; otherwise loads unless stalled.
  always_comb begin
    bubble_c = pcsrc_M | flush_D;
    load_c   = ~bubble_c & ~stall_F;
  end

  // Next PC: redirect beats stall; branch targets are forced word aligned.
  always_comb begin
    pc_d = pc_q;
    if (pcsrc_M) begin
      pc_d = pcbranch_M & ~N'(3);
    end else if (!stall_F) begin
      pc_d = pc_q + N'(4);
    end
  end

  // IF/ID register contents and the saturating fetch counter.
  always_comb begin
    pc_D_d        = pc_D_q;
    instr_D_d     = instr_D_q;
    valid_D_d     = valid_D_q;
    fetch_count_d = fetch_count_q;
    if (bubble_c) begin
      pc_D_d    = '0;
      instr_D_d = NOP_INSTR;
      valid_D_d = 1'b0;
    end else if (load_c) begin
      pc_D_d    = pc_q;
      instr_D_d = imem_q_F;
      valid_D_d = 1'b1;
      if (fetch_count_q != {CNT_W{1'b1}}) begin
        fetch_count_d = fetch_count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= '0;
      pc_D_q        <= '0;
      instr_D_q     <= NOP_INSTR;
      valid_D_q     <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      pc_D_q        <= pc_D_d;
      instr_D_q     <= instr_D_d;
      valid_D_q     <= valid_D_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // ROM address is the word index of the PC; addresses alias modulo the ROM size.
  assign imem_addr_F = pc_q[IMEM_AW+1:2];
  assign pc_D        = pc_D_q;
  assign instr_D     = instr_D_q;
  assign valid_D     = valid_D_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a combinational ROM model.
module tb_fetch_stage;

  localparam int unsigned N = 64;
  localparam int unsigned AW = 7;
  localparam logic [31:0] NOP = 32'h8b1f03ff;

  logic          clk, reset, stall_F, flush_D, pcsrc_M;
  logic [N-1:0]  pcbranch_M;
  logic [AW-1:0] imem_addr_F;
  logic [31:0]   imem_q_F;
  logic [N-1:0]  pc_D;
  logic [31:0]   instr_D;
  logic          valid_D;
  logic [31:0]   fetch_count;

  logic [31:0] rom [128];
  int total = 0;
  int bad = 0;

  fetch_stage #(.N(N), .IMEM_AW(AW), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .stall_F(stall_F), .flush_D(flush_D),
    .pcsrc_M(pcsrc_M), .pcbranch_M(pcbranch_M), .imem_addr_F(imem_addr_F),
    .imem_q_F(imem_q_F), .pc_D(pc_D), .instr_D(instr_D), .valid_D(valid_D),
    .fetch_count(fetch_count)
  );

  assign imem_q_F = rom[imem_addr_F];

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; stall_F = 1; pcsrc_M = 1; flush_D = 0; pcbranch_M = 64'h40;
    step(); step();
    total++; if (pc_D !== 64'h0) begin bad++; $display("FAIL reset_pc_D got=%h exp=0", pc_D); end
    total++; if (instr_D !== NOP) begin bad++; $display("FAIL reset_instr_D got=%h exp=%h", instr_D, NOP); end
    total++; if (valid_D !== 1'b0) begin bad++; $display("FAIL reset_valid_D got=%b exp=0", valid_D); end
    total++; if (fetch_count !== 32'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", fetch_count); end
    total++; if (imem_addr_F !== 7'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", imem_addr_F); end
    reset = 0; stall_F = 0; pcsrc_M = 0; pcbranch_M = '0;
  endtask

  task automatic test_fetch();
    step();
    total++; if (pc_D !== 64'h0) begin bad++; $display("FAIL fetch0_pc_D got=%h exp=0", pc_D); end
    total++; if (instr_D !== 32'hf8000001) begin bad++; $display("FAIL fetch0_instr got=%h exp=f8000001", instr_D); end
    total++; if (valid_D !== 1'b1) begin bad++; $display("FAIL fetch0_valid got=%b exp=1", valid_D); end
    step();
    total++; if (pc_D !== 64'h4) begin bad++; $display("FAIL fetch1_pc_D got=%h exp=4", pc_D); end
    total++; if (instr_D !== 32'hf8008002) begin bad++; $display("FAIL fetch1_instr got=%h exp=f8008002", instr_D); end
    total++; if (fetch_count !== 32'd2) begin bad++; $display("FAIL fetch1_count got=%0d exp=2", fetch_count); end
    total++; if (imem_addr_F !== 7'd2) begin bad++; $display("FAIL fetch1_addr got=%0d exp=2", imem_addr_F); end
  endtask

  task automatic test_stall();
    stall_F = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      total++; if (imem_addr_F !== 7'd2) begin bad++; $display("FAIL stall_addr cyc=%0d got=%0d exp=2", i, imem_addr_F); end
      total++; if (instr_D !== 32'hf8008002) begin bad++; $display("FAIL stall_instr cyc=%0d got=%h exp=f8008002", i, instr_D); end
      total++; if (fetch_count !== 32'd2) begin bad++; $display("FAIL stall_count cyc=%0d got=%0d exp=2", i, fetch_count); end
    end
    stall_F = 0;
    step();
    total++; if (instr_D !== 32'h8b050083) begin bad++; $display("FAIL stall_rel_instr got=%h exp=8b050083", instr_D); end
    total++; if (pc_D !== 64'h8) begin bad++; $display("FAIL stall_rel_pc_D got=%h exp=8", pc_D); end
    total++; if (fetch_count !== 32'd3) begin bad++; $display("FAIL stall_rel_count got=%0d exp=3", fetch_count); end
  endtask

  task automatic test_flush();
    total++; if (imem_addr_F !== 7'd3) begin bad++; $display("FAIL flush_pre_addr got=%0d exp=3", imem_addr_F); end
    flush_D = 1;
    step();
    flush_D = 0;
    total++; if (valid_D !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", valid_D); end
    total++; if (instr_D !== NOP) begin bad++; $display("FAIL flush_instr got=%h exp=%h", instr_D, NOP); end
    total++; if (pc_D !== 64'h0) begin bad++; $display("FAIL flush_pc_D got=%h exp=0", pc_D); end
    total++; if (imem_addr_F !== 7'd4) begin bad++; $display("FAIL flush_addr got=%0d exp=4", imem_addr_F); end
    total++; if (fetch_count !== 32'd3) begin bad++; $display("FAIL flush_count got=%0d exp=3", fetch_count); end
  endtask

  task automatic test_branch_stall();
    pcsrc_M = 1; pcbranch_M = 64'h10; stall_F = 1;
    step();
    pcsrc_M = 0; stall_F = 0; pcbranch_M = '0;
    total++; if (valid_D !== 1'b0) begin bad++; $display("FAIL br_valid got=%b exp=0", valid_D); end
    total++; if (instr_D !== NOP) begin bad++; $display("FAIL br_instr got=%h exp=%h", instr_D, NOP); end
    total++; if (imem_addr_F !== 7'd4) begin bad++; $display("FAIL br_addr got=%0d exp=4", imem_addr_F); end
    step();
    total++; if (instr_D !== 32'hf8400006) begin bad++; $display("FAIL br_tgt_instr got=%h exp=f8400006", instr_D); end
    total++; if (pc_D !== 64'h10) begin bad++; $display("FAIL br_tgt_pc_D got=%h exp=10", pc_D); end
    total++; if (fetch_count !== 32'd4) begin bad++; $display("FAIL br_tgt_count got=%0d exp=4", fetch_count); end
  endtask

  task automatic test_flush_stall();
    flush_D = 1; stall_F = 1;
    step();
    flush_D = 0; stall_F = 0;
    total++; if (valid_D !== 1'b0) begin bad++; $display("FAIL fs_valid got=%b exp=0", valid_D); end
    total++; if (imem_addr_F !== 7'd5) begin bad++; $display("FAIL fs_addr got=%0d exp=5", imem_addr_F); end
    total++; if (fetch_count !== 32'd4) begin bad++; $display("FAIL fs_count got=%0d exp=4", fetch_count); end
    step();
    total++; if (pc_D !== 64'h14) begin bad++; $display("FAIL fs_rel_pc_D got=%h exp=14", pc_D); end
    total++; if (instr_D !== 32'h8b0a00c7) begin bad++; $display("FAIL fs_rel_instr got=%h exp=8b0a00c7", instr_D); end
  endtask

  task automatic test_wrap();
    pcsrc_M = 1; pcbranch_M = 64'h1FE;
    step();
    pcsrc_M = 0; pcbranch_M = '0;
    total++; if (imem_addr_F !== 7'd127) begin bad++; $display("FAIL wrap_addr127 got=%0d exp=127", imem_addr_F); end
    step();
    total++; if (pc_D !== 64'h1FC) begin bad++; $display("FAIL wrap_pc_D got=%h exp=1fc", pc_D); end
    total++; if (instr_D !== 32'h0) begin bad++; $display("FAIL wrap_instr got=%h exp=0", instr_D); end
    total++; if (imem_addr_F !== 7'd0) begin bad++; $display("FAIL wrap_addr0 got=%0d exp=0", imem_addr_F); end
    step();
    total++; if (pc_D !== 64'h200) begin bad++; $display("FAIL wrap_pc_D200 got=%h exp=200", pc_D); end
    total++; if (instr_D !== 32'hf8000001) begin bad++; $display("FAIL wrap_alias_instr got=%h exp=f8000001", instr_D); end
    total++; if (fetch_count !== 32'd7) begin bad++; $display("FAIL wrap_count got=%0d exp=7", fetch_count); end
  endtask

  task automatic test_pc_wrap64();
    pcsrc_M = 1; pcbranch_M = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    pcsrc_M = 0; pcbranch_M = '0;
    step();
    total++; if (pc_D !== 64'hFFFF_FFFF_FFFF_FFFC) begin bad++; $display("FAIL pc64_top got=%h exp=fffffffffffffffc", pc_D); end
    step();
    total++; if (pc_D !== 64'h0) begin bad++; $display("FAIL pc64_wrap got=%h exp=0", pc_D); end
    total++; if (fetch_count !== 32'd9) begin bad++; $display("FAIL pc64_count got=%0d exp=9", fetch_count); end
  endtask

  task automatic test_mid_reset();
    pcsrc_M = 1; pcbranch_M = 64'h18;
    step();
    pcsrc_M = 0; pcbranch_M = '0;
    total++; if (imem_addr_F !== 7'd6) begin bad++; $display("FAIL mr_pre_addr got=%0d exp=6", imem_addr_F); end
    reset = 1; stall_F = 1; pcsrc_M = 1; pcbranch_M = 64'h40;
    step();
    reset = 0; stall_F = 0; pcsrc_M = 0; pcbranch_M = '0;
    total++; if (imem_addr_F !== 7'd0) begin bad++; $display("FAIL mr_addr got=%0d exp=0", imem_addr_F); end
    total++; if (valid_D !== 1'b0) begin bad++; $display("FAIL mr_valid got=%b exp=0", valid_D); end
    total++; if (instr_D !== NOP) begin bad++; $display("FAIL mr_instr got=%h exp=%h", instr_D, NOP); end
    total++; if (fetch_count !== 32'd0) begin bad++; $display("FAIL mr_count got=%0d exp=0", fetch_count); end
    step();
    total++; if (instr_D !== 32'hf8000001) begin bad++; $display("FAIL mr_rel_instr got=%h exp=f8000001", instr_D); end
    total++; if (fetch_count !== 32'd1) begin bad++; $display("FAIL mr_rel_count got=%0d exp=1", fetch_count); end
  endtask

  initial begin
    clk = 0; reset = 1; stall_F = 0; flush_D = 0; pcsrc_M = 0; pcbranch_M = '0;
    for (int i = 0; i < 128; i++) rom[i] = 32'h0;
    rom[0] = 32'hf8000001; rom[1] = 32'hf8008002; rom[2] = 32'h8b050083;
    rom[3] = 32'h8b0800a4; rom[4] = 32'hf8400006; rom[5] = 32'h8b0a00c7;
    rom[6] = 32'hcb050108; rom[7] = 32'hf8018008; rom[8] = 32'hf8420009;
    test_reset();
    test_fetch();
    test_stall();
    test_flush();
    test_branch_stall();
    test_flush_stall();
    test_wrap();
    test_pc_wrap64();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
